// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and constants for the two-requester ALU arbiter.
// Consumed by alu_arb_if, alu_arb_rsp_slot and alu_arbiter.
package alu_arb_pkg;

  // The ALU datapath is fixed at 16 bits.
  localparam int ALU_W = 16;

  typedef logic [3:0] alu_op_t;

  // Opcodes are carried through untouched; names exist for readability only.
  localparam alu_op_t OP_SUB    = 4'b0000;
  localparam alu_op_t OP_ADD    = 4'b0001;
  localparam alu_op_t OP_XOR    = 4'b0010;
  localparam alu_op_t OP_ANDN   = 4'b0011;
  localparam alu_op_t OP_ROL    = 4'b0100;
  localparam alu_op_t OP_SLL    = 4'b0101;
  localparam alu_op_t OP_ROR    = 4'b0110;
  localparam alu_op_t OP_SRL    = 4'b0111;
  localparam alu_op_t OP_SEQ    = 4'b1000;
  localparam alu_op_t OP_SLT    = 4'b1001;
  localparam alu_op_t OP_SLE    = 4'b1010;
  localparam alu_op_t OP_SCO    = 4'b1011;
  localparam alu_op_t OP_BTR    = 4'b1100;
  localparam alu_op_t OP_PASS   = 4'b1101;
  localparam alu_op_t OP_SLBI_0 = 4'b1110;
  localparam alu_op_t OP_SLBI_1 = 4'b1111;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

  // A response slot can take a new result when empty or when it is being drained now.
  function automatic logic slot_free_f(input logic valid, input logic ready);
    return (!valid) || ready;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arb_if: request, response and ALU-side signals of the ALU arbiter.
// slave = arbiter view, master = requesters / consumers / ALU view.
interface alu_arb_if;
  import alu_arb_pkg::*;

  logic             req0_valid;
  logic             req0_ready;
  alu_op_t          req0_op;
  logic [ALU_W-1:0] req0_a;
  logic [ALU_W-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  alu_op_t          req1_op;
  logic [ALU_W-1:0] req1_a;
  logic [ALU_W-1:0] req1_b;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [ALU_W-1:0] rsp0_out;
  logic             rsp0_msb;
  logic             rsp0_zero;

  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [ALU_W-1:0] rsp1_out;
  logic             rsp1_msb;
  logic             rsp1_zero;

  alu_op_t          alu_op;
  logic [ALU_W-1:0] alu_ina;
  logic [ALU_W-1:0] alu_inb;
  logic [ALU_W-1:0] alu_out;
  logic             alu_msb;
  logic             alu_zero;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    input  rsp0_ready, rsp1_ready,
    output rsp0_valid, rsp0_out, rsp0_msb, rsp0_zero,
    output rsp1_valid, rsp1_out, rsp1_msb, rsp1_zero,
    output alu_op, alu_ina, alu_inb,
    input  alu_out, alu_msb, alu_zero
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    output rsp0_ready, rsp1_ready,
    input  rsp0_valid, rsp0_out, rsp0_msb, rsp0_zero,
    input  rsp1_valid, rsp1_out, rsp1_msb, rsp1_zero,
    input  alu_op, alu_ina, alu_inb,
    output alu_out, alu_msb, alu_zero
  );

endinterface

// File: rtl/alu_arb_rsp_slot.sv
// alu_arb_rsp_slot: one-deep valid/ready holding register for one requester's
// ALU result. A drained slot may be reloaded in the same cycle.
module alu_arb_rsp_slot
  import alu_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             rsp_ready,
  input  logic [ALU_W-1:0] alu_out,
  input  logic             alu_msb,
  input  logic             alu_zero,
  output logic             rsp_valid,
  output logic [ALU_W-1:0] rsp_out,
  output logic             rsp_msb,
  output logic             rsp_zero,
  output logic             slot_free
);

  logic             valid_r;
  logic [ALU_W-1:0] out_r;
  logic             msb_r;
  logic             zero_r;

  // Occupancy: set on load, cleared when the consumer drains with nothing new arriving.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
    end else if (rsp_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Result capture: sample the ALU outputs on load, otherwise hold the last result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r  <= {ALU_W{1'b0}};
      msb_r  <= 1'b0;
      zero_r <= 1'b0;
    end else if (load) begin
      out_r  <= alu_out;
      msb_r  <= alu_msb;
      zero_r <= alu_zero;
    end else begin
      out_r  <= out_r;
      msb_r  <= msb_r;
      zero_r <= zero_r;
    end
  end

  assign slot_free = slot_free_f(valid_r, rsp_ready);
  assign rsp_valid = valid_r;
  assign rsp_out   = out_r;
  assign rsp_msb   = msb_r;
  assign rsp_zero  = zero_r;

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: time-shares one combinational 16-bit ALU between the execute
// stage (requester 0) and an auxiliary unit (requester 1).
// Build option: define ALU_ARB_RR_EN for round-robin tie-break; without it,
// requester 0 always wins ties and requester 1 may starve.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int      DATA_W  = 16,
  parameter alu_op_t IDLE_OP = OP_PASS
) (
  input logic      clk,
  input logic      rst,
  alu_arb_if.slave bus
);

  logic              free0_s;
  logic              free1_s;
  logic [1:0]        elig_s;
  logic [1:0]        grant_s;
  alu_op_t           op_s;
  logic [DATA_W-1:0] ina_s;
  logic [DATA_W-1:0] inb_s;

  // A requester competes only if its response slot can absorb the result.
  assign elig_s = {bus.req1_valid & free1_s, bus.req0_valid & free0_s};

`ifdef ALU_ARB_RR_EN
  req_id_t last_gnt_r;

  // Remember the most recently served requester; reset favours requester 0 on the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_r <= REQ1;
    end else if (grant_s[0]) begin
      last_gnt_r <= REQ0;
    end else if (grant_s[1]) begin
      last_gnt_r <= REQ1;
    end else begin
      last_gnt_r <= last_gnt_r;
    end
  end

  // Grant selection: a lone eligible requester wins; a tie goes to the one not served last.
  always_comb begin
    grant_s = 2'b00;
    case (elig_s)
      2'b01:   grant_s = 2'b01;
      2'b10:   grant_s = 2'b10;
      2'b11:   grant_s = (last_gnt_r == REQ1) ? 2'b01 : 2'b10;
      default: grant_s = 2'b00;
    endcase
  end
`else
  // Grant selection: a lone eligible requester wins; requester 0 always wins a tie.
  always_comb begin
    grant_s = 2'b00;
    case (elig_s)
      2'b01:   grant_s = 2'b01;
      2'b10:   grant_s = 2'b10;
      2'b11:   grant_s = 2'b01;
      default: grant_s = 2'b00;
    endcase
  end
`endif

  // ALU input steering: granted requester's op/operands, else the idle passthrough of zero.
  always_comb begin
    op_s  = IDLE_OP;
    ina_s = {DATA_W{1'b0}};
    inb_s = {DATA_W{1'b0}};
    case (grant_s)
      2'b01: begin
        op_s  = bus.req0_op;
        ina_s = bus.req0_a;
        inb_s = bus.req0_b;
      end
      2'b10: begin
        op_s  = bus.req1_op;
        ina_s = bus.req1_a;
        inb_s = bus.req1_b;
      end
      default: begin
        op_s  = IDLE_OP;
        ina_s = {DATA_W{1'b0}};
        inb_s = {DATA_W{1'b0}};
      end
    endcase
  end

  assign bus.alu_op     = op_s;
  assign bus.alu_ina    = ina_s;
  assign bus.alu_inb    = inb_s;
  assign bus.req0_ready = grant_s[0];
  assign bus.req1_ready = grant_s[1];

  alu_arb_rsp_slot u_slot0 (
    .clk       (clk),
    .rst       (rst),
    .load      (grant_s[0]),
    .rsp_ready (bus.rsp0_ready),
    .alu_out   (bus.alu_out),
    .alu_msb   (bus.alu_msb),
    .alu_zero  (bus.alu_zero),
    .rsp_valid (bus.rsp0_valid),
    .rsp_out   (bus.rsp0_out),
    .rsp_msb   (bus.rsp0_msb),
    .rsp_zero  (bus.rsp0_zero),
    .slot_free (free0_s)
  );

  alu_arb_rsp_slot u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .load      (grant_s[1]),
    .rsp_ready (bus.rsp1_ready),
    .alu_out   (bus.alu_out),
    .alu_msb   (bus.alu_msb),
    .alu_zero  (bus.alu_zero),
    .rsp_valid (bus.rsp1_valid),
    .rsp_out   (bus.rsp1_out),
    .rsp_msb   (bus.rsp1_msb),
    .rsp_zero  (bus.rsp1_zero),
    .slot_free (free1_s)
  );

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed table-driven bench for alu_arbiter plus hand-written
// sequences for reset, contention and the fixed-priority build.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_arb_if bus ();

  alu_arbiter #(.DATA_W(16), .IDLE_OP(4'b1101)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // External ALU model: SUB = InB-InA, ADD, PASS = InB, anything else XOR.
  // MSB/Zero are branch-compare flags on InA (sign bit, InA == 0).
  always_comb begin
    case (bus.alu_op)
      4'b0000: bus.alu_out = bus.alu_inb - bus.alu_ina;
      4'b0001: bus.alu_out = bus.alu_ina + bus.alu_inb;
      4'b1101: bus.alu_out = bus.alu_inb;
      default: bus.alu_out = bus.alu_ina ^ bus.alu_inb;
    endcase
    bus.alu_msb  = bus.alu_ina[15];
    bus.alu_zero = (bus.alu_ina == 16'h0000);
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        v0;
    logic [3:0]  op0;
    logic [15:0] a0;
    logic [15:0] b0;
    logic        rr0;
    logic        v1;
    logic [3:0]  op1;
    logic [15:0] a1;
    logic [15:0] b1;
    logic        rr1;
    logic        e_rdy0;
    logic        e_rdy1;
    logic [3:0]  e_op;
    logic [15:0] e_ina;
    logic [15:0] e_inb;
    logic        e_rv0;
    logic [15:0] e_out0;
    logic        e_msb0;
    logic        e_zero0;
    logic        e_rv1;
    logic [15:0] e_out1;
    logic        e_msb1;
    logic        e_zero1;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs[NVEC];

`ifdef ALU_ARB_RR_EN
  localparam int CONT_N = 8;
  localparam int EXP_C0 = 4;
  localparam int EXP_C1 = 4;
`else
  localparam int CONT_N = 10;
  localparam int EXP_C0 = 10;
  localparam int EXP_C1 = 0;
`endif

  task automatic drive_idle();
    bus.req0_valid = 1'b0; bus.req0_op = 4'b0000; bus.req0_a = 16'h0000; bus.req0_b = 16'h0000;
    bus.req1_valid = 1'b0; bus.req1_op = 4'b0000; bus.req1_a = 16'h0000; bus.req1_b = 16'h0000;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
  endtask

  // One cycle: drive, check combinational grant/ALU side, clock, check response slots.
  task automatic step(input int k);
    vec_t v;
    v = vecs[k];
    bus.req0_valid = v.v0; bus.req0_op = v.op0; bus.req0_a = v.a0; bus.req0_b = v.b0;
    bus.req1_valid = v.v1; bus.req1_op = v.op1; bus.req1_a = v.a1; bus.req1_b = v.b1;
    bus.rsp0_ready = v.rr0; bus.rsp1_ready = v.rr1;
    #1;
    check($sformatf("v%0d req0_ready", k), {15'd0, bus.req0_ready}, {15'd0, v.e_rdy0});
    check($sformatf("v%0d req1_ready", k), {15'd0, bus.req1_ready}, {15'd0, v.e_rdy1});
    check($sformatf("v%0d alu_op", k), {12'd0, bus.alu_op}, {12'd0, v.e_op});
    check($sformatf("v%0d alu_ina", k), bus.alu_ina, v.e_ina);
    check($sformatf("v%0d alu_inb", k), bus.alu_inb, v.e_inb);
    @(posedge clk);
    #1;
    check($sformatf("v%0d rsp0_valid", k), {15'd0, bus.rsp0_valid}, {15'd0, v.e_rv0});
    check($sformatf("v%0d rsp0_out", k), bus.rsp0_out, v.e_out0);
    check($sformatf("v%0d rsp0_msb", k), {15'd0, bus.rsp0_msb}, {15'd0, v.e_msb0});
    check($sformatf("v%0d rsp0_zero", k), {15'd0, bus.rsp0_zero}, {15'd0, v.e_zero0});
    check($sformatf("v%0d rsp1_valid", k), {15'd0, bus.rsp1_valid}, {15'd0, v.e_rv1});
    check($sformatf("v%0d rsp1_out", k), bus.rsp1_out, v.e_out1);
    check($sformatf("v%0d rsp1_msb", k), {15'd0, bus.rsp1_msb}, {15'd0, v.e_msb1});
    check($sformatf("v%0d rsp1_zero", k), {15'd0, bus.rsp1_zero}, {15'd0, v.e_zero1});
  endtask

  initial begin
    int  c0;
    int  c1;
    logic g1;

    //            v0    op0      a0        b0        rr0   v1    op1      a1        b1        rr1   rdy0  rdy1  op       ina       inb       rv0   out0      msb0  zero0 rv1   out1      msb1  zero1
    vecs[0]  = '{1'b0, 4'b0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'b0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4'b1101, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'b0001, 16'h0003, 16'h0004, 1'b1, 1'b0, 4'b0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 4'b0001, 16'h0003, 16'h0004, 1'b1, 16'h0007, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'b0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 4'b0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4'b1101, 16'h0000, 16'h0000, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 4'b0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 4'b1101, 16'h8000, 16'h1234, 1'b1, 1'b0, 1'b1, 4'b1101, 16'h8000, 16'h1234, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 4'b0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 4'b1101, 16'h0000, 16'h1234, 1'b1, 1'b0, 1'b1, 4'b1101, 16'h0000, 16'h1234, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 4'b0001, 16'h0010, 16'h0020, 1'b1, 1'b1, 4'b0001, 16'h0001, 16'h0001, 1'b0, 1'b1, 1'b0, 4'b0001, 16'h0010, 16'h0020, 1'b1, 16'h0030, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 4'b0001, 16'h0011, 16'h0020, 1'b1, 1'b1, 4'b0001, 16'h0001, 16'h0001, 1'b0, 1'b1, 1'b0, 4'b0001, 16'h0011, 16'h0020, 1'b1, 16'h0031, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 4'b0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 4'b0001, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b1, 4'b0001, 16'h0001, 16'h0001, 1'b0, 16'h0031, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 4'b0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 4'b0001, 16'h0005, 16'h0006, 1'b0, 1'b0, 1'b0, 4'b1101, 16'h0000, 16'h0000, 1'b0, 16'h0031, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 4'b1110, 16'h00F0, 16'h000F, 1'b1, 1'b1, 4'b0001, 16'h0005, 16'h0006, 1'b0, 1'b1, 1'b0, 4'b1110, 16'h00F0, 16'h000F, 1'b1, 16'h00FF, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 4'b0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 4'b0001, 16'h0005, 16'h0006, 1'b1, 1'b0, 1'b1, 4'b0001, 16'h0005, 16'h0006, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b1, 16'h000B, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 4'b0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 4'b0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 4'b1101, 16'h0000, 16'h0000, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0, 16'h000B, 1'b0, 1'b0};

    // Reset held across clock edges.
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst rsp0_valid", {15'd0, bus.rsp0_valid}, 16'h0000);
    check("rst rsp1_valid", {15'd0, bus.rsp1_valid}, 16'h0000);
    check("rst rsp0_out", bus.rsp0_out, 16'h0000);
    check("rst rsp1_out", bus.rsp1_out, 16'h0000);
    check("rst rsp0_flags", {14'd0, bus.rsp0_msb, bus.rsp0_zero}, 16'h0000);
    check("rst rsp1_flags", {14'd0, bus.rsp1_msb, bus.rsp1_zero}, 16'h0000);
    check("rst alu_op", {12'd0, bus.alu_op}, 16'h000D);
    check("rst alu_ina", bus.alu_ina, 16'h0000);
    check("rst alu_inb", bus.alu_inb, 16'h0000);
    check("rst readys", {14'd0, bus.req1_ready, bus.req0_ready}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < NVEC; k++) begin
      step(k);
    end

    // Asynchronous reset mid-cycle drops a held response without a clock edge.
    drive_idle();
    bus.req0_valid = 1'b1; bus.req0_op = 4'b0000; bus.req0_a = 16'h0010; bus.req0_b = 16'h0001;
    bus.rsp0_ready = 1'b1;
    @(posedge clk);
    #1;
    check("arst pre rsp0_valid", {15'd0, bus.rsp0_valid}, 16'h0001);
    check("arst pre rsp0_out", bus.rsp0_out, 16'hFFF1);
    bus.req0_valid = 1'b0;
    bus.rsp0_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst rsp0_valid", {15'd0, bus.rsp0_valid}, 16'h0000);
    check("arst rsp0_out", bus.rsp0_out, 16'h0000);
    check("arst rsp1_out", bus.rsp1_out, 16'h0000);
    // An accept attempted while reset is held must leave no response.
    bus.req0_valid = 1'b1;
    @(posedge clk);
    #1;
    check("arst lost accept", {15'd0, bus.rsp0_valid}, 16'h0000);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Contention: both requesters valid every cycle, responses always taken.
    bus.req0_valid = 1'b1; bus.req0_op = 4'b0000; bus.req0_a = 16'h0010; bus.req0_b = 16'h0001;
    bus.req1_valid = 1'b1; bus.req1_op = 4'b0000; bus.req1_a = 16'h0010; bus.req1_b = 16'h0001;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    c0 = 0;
    c1 = 0;
    for (int i = 0; i < CONT_N; i++) begin
`ifdef ALU_ARB_RR_EN
      g1 = (i % 2) == 1;
`else
      g1 = 1'b0;
`endif
      #1;
      check($sformatf("cont%0d req0_ready", i), {15'd0, bus.req0_ready}, {15'd0, ~g1});
      check($sformatf("cont%0d req1_ready", i), {15'd0, bus.req1_ready}, {15'd0, g1});
      @(posedge clk);
      #1;
      check($sformatf("cont%0d rsp0_valid", i), {15'd0, bus.rsp0_valid}, {15'd0, ~g1});
      check($sformatf("cont%0d rsp1_valid", i), {15'd0, bus.rsp1_valid}, {15'd0, g1});
      check($sformatf("cont%0d rsp_out", i), g1 ? bus.rsp1_out : bus.rsp0_out, 16'hFFF1);
      if (bus.rsp0_valid) c0++;
      if (bus.rsp1_valid) c1++;
    end
    check("cont count0", c0[15:0], EXP_C0[15:0]);
    check("cont count1", c1[15:0], EXP_C1[15:0]);

    drive_idle();
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter that time-shares the single combinational 16-bit ALU between the execute stage (requester 0) and an auxiliary unit such as branch compare or address generation (requester 1). Each requester presents op/operands with a valid/ready handshake. The arbiter grants at most one request per cycle, drives the ALU, and captures the result into a one-deep per-requester response register. Arbitration is round-robin, or fixed-priority when built without the round-robin feature.

## Interface
Parameters:
- DATA_W, 16, operand/result width; only 16 is legal (ALU is fixed 16-bit)
- IDLE_OP, 4'b1101, ALU op driven when nothing is granted (passthrough)

Ports:
- clk  in  1  single clock
- rst  in  1  reset, asynchronous, active-high
- reqN_valid  in  1  request N present (N = 0, 1)
- reqN_ready  out  1  request N accepted this cycle
- reqN_op  in  4  ALU opcode
- reqN_a  in  16  ALU InA operand
- reqN_b  in  16  ALU InB operand
- rspN_valid  out  1  response N held
- rspN_ready  in  1  consumer takes response N
- rspN_out  out  16  captured ALU Out
- rspN_msb  out  1  captured ALU MSB
- rspN_zero  out  1  captured ALU Zero
- alu_op  out  4  to ALU Op
- alu_ina  out  16  to ALU InA
- alu_inb  out  16  to ALU InB
- alu_out  in  16  from ALU Out
- alu_msb  in  1  from ALU MSB
- alu_zero  in  1  from ALU Zero

## Operation
- slot_free[N] = !rspN_valid || rspN_ready (pass-through: a drained slot refills in the same cycle).
- eligible[N] = reqN_valid && slot_free[N]; grant goes to one eligible requester; reqN_ready = grant[N]; at most one ready is high per cycle.
- Tie (both eligible): grant the requester not recorded in last_gnt. last_gnt updates only on an accepted request.
- Granted: alu_op/alu_ina/alu_inb = reqN_op/a/b (combinational). No grant: IDLE_OP, 16'h0000, 16'h0000.
- On accept: at the clock edge, rspN_out/msb/zero <= alu_out/msb/zero, rspN_valid <= 1.
- Drain: rspN_valid && rspN_ready with no new accept -> rspN_valid <= 0; data holds its last value.
- Opcodes pass through unchanged; 4'b1110 and 4'b1111 are treated identically to any other op. The arbiter does no decoding.
- Requester rules: reqN_valid must not depend on reqN_ready; op/a/b stay stable while valid && !ready.
- State: last_gnt (1 bit), two response slots. No other state.

## Timing
- Reset values: rspN_valid=0, rspN_out=16'h0000, rspN_msb=0, rspN_zero=0, last_gnt=1 (requester 0 wins the first tie). ALU outputs are then idle values; reqN_ready=0 until valid.
- Reset clears all of the above asynchronously. An in-flight accept in the reset cycle is lost, and no response is produced.
- Latency: request accepted at edge k -> rspN_valid high after edge k; data valid from then.
- Throughput: 1 op/cycle total. Each requester gets 1 op/cycle when alone, and 1 op per 2 cycles under contention (round-robin).
- reqN_ready is combinational from reqN_valid, rspN_valid, rspN_ready and last_gnt. No combinational path from alu_* inputs to any ready.

## Configuration
- ALU_ARB_RR_EN defined: round-robin tie-break via last_gnt, as above.
- ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins ties. last_gnt is not implemented, and requester 1 can starve.

## Structure
- Package alu_arb_pkg holds:
  - alu_op_t (4-bit)
  - named opcode constants (SUB=0000 … PASS=1101, SLBI=1110/1111)
  - ALU_W=16
  - req_id_t (REQ0, REQ1)
- Sub-module alu_arb_rsp_slot: one-deep valid/ready result register (load, drain, slot_free), instantiated twice.

## Test plan
- Reset: hold rst, toggle the clock. All rspN_* are 0. With no valid, alu_op=1101 and operands are 0. Release, then assert rst asynchronously mid-cycle: rspN_valid drops without waiting for an edge.
- Single op: req0 op=0001 a=0x0003 b=0x0004, rsp0_ready=1 -> req0_ready=1 same cycle. Next cycle rsp0_out=0x0007, msb=0, zero=0, rsp0_valid=1 for one cycle.
- Contention: both valid for 4 ops each (SUB, a=0x0010 b=0x0001), responses always ready -> grants alternate 0,1,0,1…. All 8 complete in 8 cycles; each rspN_out=0xFFF1 (ALU computes InB−InA).
- Backpressure: rsp1_ready=0 with rsp1 full -> req1_ready=0 while req0 keeps getting 1 op/cycle. Raise rsp1_ready -> req1 accepted in that same cycle, and the new result appears next cycle.
- Flags: req1 op=1101 a=0x8000 b=0x1234 -> rsp1_out=0x1234, rsp1_msb=1, rsp1_zero=0. Then a=0x0000 -> rsp1_zero=1.
- Fixed-priority build (ALU_ARB_RR_EN undefined): both valid for 10 cycles -> req1_ready stays 0 throughout, and req0 completes 10 ops.
